led_matrix_scan: RTL and testbench
==================================

# led_matrix_scan

Row-multiplexing driver for the 5x5 RGB LED matrix. It sits directly downstream of the frame shifter and consumes its three 25-bit R/G/B colour vectors. It latches a full frame at each frame boundary to prevent tearing, then scans the five rows one at a time. Each row gets an anti-ghosting blanking gap and 8-step global-brightness PWM before the signals reach the board's row/column pins.

## Interface
- `SUB_TICKS`, default 1024: clock cycles per PWM sub-step (≥1).
- `BLANK_TICKS`, default 16: clock cycles of all-off blanking before each row (≥1).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `R`  in  25  red frame bits; bit index = row*5 + col.
- `G`  in  25  green frame bits, same mapping.
- `B`  in  25  blue frame bits, same mapping.
- `bright`  in  3  global brightness; duty = (bright+1)/8.
- `row_n`  out  5  row select, active-low, at most one bit low.
- `col_r`  out  5  red column drive, active-high.
- `col_g`  out  5  green column drive, active-high.
- `col_b`  out  5  blue column drive, active-high.
- `frame_start`  out  1  one-cycle pulse in the frame-load cycle.

## Operation
- FSM states:
  - LOAD: exactly 1 cycle. Latches R/G/B into the frame registers and `bright` into the brightness register. Sets row=0. Goes to BLANK.
  - BLANK: lasts BLANK_TICKS cycles. `row_n`=5'b11111 and all `col_*`=0. Goes to ACTIVE.
  - ACTIVE: lasts 8*SUB_TICKS cycles, split into sub-steps 0..7 of SUB_TICKS cycles each.
    - `row_n[row]`=0; all other `row_n` bits are 1.
    - `col_x[c]` = frame_x[row*5+c] AND (sub ≤ bright_latched).
    - At the end: if row<4, row increments and FSM goes to BLANK. If row==4, FSM goes to LOAD.
- R/G/B are sampled only in LOAD. Input changes at any other time have no visible effect until the next frame.
- `bright` is sampled only in LOAD, so brightness changes take effect at frame granularity.
- Counters:
  - tick counter: ceil(log2(max(SUB_TICKS, BLANK_TICKS))) bits; cleared on every state or sub-step change.
  - sub-step counter: 3 bits; wraps 7→0 only on the ACTIVE exit.
  - row counter: 3 bits, range 0..4. Values 5..7 are unreachable; if ever present, the row counter is forced to 0 via LOAD.
- All outputs are decoded from registered state and latched frame only. There is no combinational path from R/G/B/bright to any output.
- Reset (any cycle, including mid-row or mid-PWM):
  - Next state LOAD; all counters 0; frame and brightness registers 0.
  - Outputs while `rst` is high: `row_n`=5'b11111, `col_*`=0, `frame_start`=0.
  - The first cycle after `rst` deasserts is LOAD.

## Timing
- Row period = BLANK_TICKS + 8*SUB_TICKS cycles.
- Frame period = 1 + 5*(BLANK_TICKS + 8*SUB_TICKS) cycles. With defaults: 41,041 cycles.
- `frame_start`=1 only in the LOAD cycle.
- First visible pixel appears BLANK_TICKS+1 cycles after LOAD begins: 1 LOAD cycle, then BLANK_TICKS cycles of blanking.
- Row select changes only at BLANK boundaries. `row_n` is never low for two rows in the same cycle, and no row is low during BLANK or LOAD.
- Column on-time per row = (bright+1)*SUB_TICKS cycles, contiguous from the start of ACTIVE.
- With bright=7, columns stay on for the whole ACTIVE window.
- Frame data presented in the LOAD cycle itself is captured. Data changing on the same edge that leaves LOAD is not captured.

## Test plan
All scenarios use SUB_TICKS=4 and BLANK_TICKS=2. Row period = 34 cycles; frame period = 171 cycles.

- **Reset/idle.** Hold `rst` 5 cycles, then release.
  - During reset: `row_n`=11111, `col_*`=0.
  - `frame_start` pulses in the first cycle after release, then again every 171 cycles.
  - `row_n` walks 11110→11101→…→01111, each low for 32 cycles, separated by 2-cycle all-high gaps.
- **Pixel mapping.** R=25'h0000001, G=25'h1000000, B=0, bright=7.
  - Row 0 ACTIVE: `col_r`=00001.
  - Row 4 ACTIVE: `col_g`=10000.
  - All other rows/colours stay 0 for all 32 cycles.
- **PWM duty.** All R/G/B bits 1; bright=2.
  - Each ACTIVE window: `col_*`=11111 for 12 cycles, then 0 for 20 cycles.
  - bright=0 gives 4 cycles on per row.
- **Frame latch / no tearing.** Change R from all-1 to 0 mid-frame (e.g. during row 2).
  - Rows 2–4 of the current frame still show 11111.
  - The next frame shows 0 starting at row 0.
  - A `bright` change mid-frame likewise takes effect only after the next `frame_start`.
- **Reset mid-operation.** Assert `rst` for 1 cycle during row 3, sub-step 5.
  - Outputs are blank that cycle.
  - LOAD occurs the next cycle; row 0 ACTIVE begins 3 cycles after `rst` deasserts.
  - The previously latched frame is discarded.
- **Invariant check (over 3 frames).**
  - At most one `row_n` bit is low in any cycle.
  - `col_*`=0 whenever `row_n`=11111.
  - `frame_start` appears exactly once per 171 cycles.

Source files
------------

// File: rtl/led_matrix_scan.sv
// Row-multiplexed driver for a 5x5 RGB LED matrix.
// A full frame and the brightness setting are latched once per frame, then each
// of the five rows is shown in turn: a short all-off blanking gap to stop ghosting,
// followed by an active window split into eight PWM sub-steps.
module led_matrix_scan #(
  parameter int SUB_TICKS   = 1024,
  parameter int BLANK_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] R,
  input  logic [24:0] G,
  input  logic [24:0] B,
  input  logic [2:0]  bright,
  output logic [4:0]  row_n,
  output logic [4:0]  col_r,
  output logic [4:0]  col_g,
  output logic [4:0]  col_b,
  output logic        frame_start
);

  localparam int MAX_TICKS = (SUB_TICKS > BLANK_TICKS) ? SUB_TICKS : BLANK_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TW-1:0] SUB_LAST   = TW'(SUB_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]  sub_q, sub_d;
  logic [2:0]  row_q, row_d;
  logic [24:0] frame_r_q, frame_r_d;
  logic [24:0] frame_g_q, frame_g_d;
  logic [24:0] frame_b_q, frame_b_d;
  logic [2:0]  bright_q, bright_d;

  logic [4:0]  row_n_q, row_n_d;
  logic [4:0]  col_r_q, col_r_d;
  logic [4:0]  col_g_q, col_g_d;
  logic [4:0]  col_b_q, col_b_d;
  logic        frame_start_q, frame_start_d;
  logic        col_on;

  // Pick the five column bits of one row; unreachable rows show nothing.
  function automatic logic [4:0] row_bits(input logic [24:0] frame, input logic [2:0] row);
    logic [4:0] bits;
    case (row)
      3'd0:    bits = frame[4:0];
      3'd1:    bits = frame[9:5];
      3'd2:    bits = frame[14:10];
      3'd3:    bits = frame[19:15];
      3'd4:    bits = frame[24:20];
      default: bits = 5'd0;
    endcase
    return bits;
  endfunction

  // Next-state logic for the scan FSM, its counters and the latched frame.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    sub_d     = sub_q;
    row_d     = row_q;
    frame_r_d = frame_r_q;
    frame_g_d = frame_g_q;
    frame_b_d = frame_b_q;
    bright_d  = bright_q;
    case (state_q)
      S_LOAD: begin
        frame_r_d = R;
        frame_g_d = G;
        frame_b_d = B;
        bright_d  = bright;
        row_d     = 3'd0;
        sub_d     = 3'd0;
        tick_d    = '0;
        state_d   = S_BLANK;
      end
      S_BLANK: begin
        if (tick_q == BLANK_LAST) begin
          tick_d  = '0;
          sub_d   = 3'd0;
          state_d = S_ACTIVE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (tick_q == SUB_LAST) begin
          tick_d = '0;
          if (sub_q == 3'd7) begin
            sub_d = 3'd0;
            // Row 4 ends the frame; a corrupted row value also recovers through LOAD.
            if (row_q >= 3'd4) begin
              state_d = S_LOAD;
            end else begin
              row_d   = row_q + 3'd1;
              state_d = S_BLANK;
            end
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        tick_d  = '0;
        sub_d   = 3'd0;
        row_d   = 3'd0;
        state_d = S_LOAD;
      end
    endcase
  end

  // Output decode from the upcoming state so the pins come straight from flops.
  always_comb begin
    col_on        = (state_d == S_ACTIVE) && (sub_d <= bright_d);
    frame_start_d = (state_d == S_LOAD);
    row_n_d       = (state_d == S_ACTIVE) ? ~(5'd1 << row_d) : 5'h1f;
    col_r_d       = col_on ? row_bits(frame_r_d, row_d) : 5'd0;
    col_g_d       = col_on ? row_bits(frame_g_d, row_d) : 5'd0;
    col_b_d       = col_on ? row_bits(frame_b_d, row_d) : 5'd0;
  end

  // State, counter, frame and output registers; reset restarts at LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      tick_q        <= '0;
      sub_q         <= 3'd0;
      row_q         <= 3'd0;
      frame_r_q     <= '0;
      frame_g_q     <= '0;
      frame_b_q     <= '0;
      bright_q      <= 3'd0;
      row_n_q       <= 5'h1f;
      col_r_q       <= 5'd0;
      col_g_q       <= 5'd0;
      col_b_q       <= 5'd0;
      frame_start_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      sub_q         <= sub_d;
      row_q         <= row_d;
      frame_r_q     <= frame_r_d;
      frame_g_q     <= frame_g_d;
      frame_b_q     <= frame_b_d;
      bright_q      <= bright_d;
      row_n_q       <= row_n_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      col_b_q       <= col_b_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Reset blanks the pins in the very cycle it is asserted, even mid-row.
  assign row_n       = rst ? 5'h1f : row_n_q;
  assign col_r       = rst ? 5'd0  : col_r_q;
  assign col_g       = rst ? 5'd0  : col_g_q;
  assign col_b       = rst ? 5'd0  : col_b_q;
  assign frame_start = frame_start_q & ~rst;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan with short tick counts (SUB_TICKS=4, BLANK_TICKS=2).
module tb_led_matrix_scan;

  localparam int SUB   = 4;
  localparam int BLK   = 2;
  localparam int ROWP  = BLK + 8 * SUB;   // 34
  localparam int FRAME = 1 + 5 * ROWP;    // 171

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] R = '0, G = '0, B = '0;
  logic [2:0]  bright = 3'd0;
  logic [4:0]  row_n, col_r, col_g, col_b;
  logic        frame_start;

  always #5 clk = ~clk;

  led_matrix_scan #(.SUB_TICKS(SUB), .BLANK_TICKS(BLK)) dut (
    .clk(clk), .rst(rst), .R(R), .G(G), .B(B), .bright(bright),
    .row_n(row_n), .col_r(col_r), .col_g(col_g), .col_b(col_b),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [4:0] row_n;
    logic [4:0] cr;
    logic [4:0] cg;
    logic [4:0] cb;
    logic       fs;
  } out_t;

  typedef struct {
    logic [24:0] r;
    logic [24:0] g;
    logic [24:0] b;
    logic [2:0]  br;
    int          exp_on;
    logic [4:0]  exp_r0;
    logic [4:0]  exp_g4;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_fs = -1;
  out_t sbq[$];

  // Reference: position inside the frame, counted from the LOAD cycle.
  int          ofs = 0;
  logic [24:0] mR = '0, mG = '0, mB = '0;
  logic [2:0]  mbr = 3'd0;

  function automatic out_t model_out(input int o, input logic r);
    out_t e;
    int p, row, q, sub;
    logic [24:0] sh;
    e = '{row_n: 5'h1f, cr: 5'd0, cg: 5'd0, cb: 5'd0, fs: 1'b0};
    if (!r) begin
      if (o == 0) begin
        e.fs = 1'b1;
      end else begin
        p   = o - 1;
        row = p / ROWP;
        q   = p % ROWP;
        if (q >= BLK) begin
          sub = (q - BLK) / SUB;
          e.row_n = 5'h1f & ~(5'd1 << row);
          if (sub <= int'(mbr)) begin
            sh = mR >> (row * 5); e.cr = sh[4:0];
            sh = mG >> (row * 5); e.cg = sh[4:0];
            sh = mB >> (row * 5); e.cb = sh[4:0];
          end
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock: queue the expectation for the cycle just driven, compare at the
  // falling edge, then advance the reference on the rising edge.
  task automatic step();
    out_t e, a;
    sbq.push_back(model_out(ofs, rst));
    @(negedge clk);
    a = {row_n, col_r, col_g, col_b, frame_start};
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cyc=%0d", cyc);
    end else begin
      e = sbq.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d ofs=%0d got row_n=%b r=%b g=%b b=%b fs=%b exp row_n=%b r=%b g=%b b=%b fs=%b",
                 cyc, ofs, a.row_n, a.cr, a.cg, a.cb, a.fs, e.row_n, e.cr, e.cg, e.cb, e.fs);
      end
    end
    checks++;
    if (!$onehot0(~row_n) || (row_n == 5'h1f && (col_r | col_g | col_b) != 5'd0)) begin
      errors++;
      $display("FAIL invariant cyc=%0d row_n=%b cols=%b/%b/%b", cyc, row_n, col_r, col_g, col_b);
    end
    if (rst) begin
      last_fs = -1;
    end else if (frame_start) begin
      if (last_fs >= 0) begin
        checks++;
        if (cyc - last_fs != FRAME) begin
          errors++;
          $display("FAIL fs_period got=%0d exp=%0d", cyc - last_fs, FRAME);
        end
      end
      last_fs = cyc;
    end
    cyc++;
    @(posedge clk);
    if (rst) begin
      ofs = 0;
    end else begin
      if (ofs == 0) begin
        mR = R; mG = G; mB = B; mbr = bright;
      end
      ofs = (ofs == FRAME - 1) ? 0 : ofs + 1;
    end
    #1;
  endtask

  // Advance until the DUT is in its LOAD cycle, bounded.
  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame_start got=timeout exp=pulse");
    end
  endtask

  vec_t vecs[5];
  int   on_cnt;
  logic [4:0] r0_or, g4_or;

  initial begin
    vecs[0] = '{25'h0000001, 25'h1000000, 25'h0,       3'd7, 32, 5'b00001, 5'b10000};
    vecs[1] = '{25'h1ffffff, 25'h1ffffff, 25'h1ffffff, 3'd2, 12, 5'b11111, 5'b11111};
    vecs[2] = '{25'h1ffffff, 25'h1ffffff, 25'h1ffffff, 3'd0,  4, 5'b11111, 5'b11111};
    vecs[3] = '{25'h000001f, 25'h0,       25'h0,       3'd5, 24, 5'b11111, 5'b00000};
    vecs[4] = '{25'h0,       25'h1f00000, 25'h0aaaaaa, 3'd3,  0, 5'b00000, 5'b11111};

    // Reset held for five cycles, then the first LOAD.
    @(posedge clk); #1;
    chk("reset_row_n", 32'(row_n), 32'h1f);
    repeat (5) step();
    rst = 1'b0;
    #1;
    chk("first_frame_start", 32'(frame_start), 32'h1);

    // Table-driven frames: mapping and duty per brightness.
    for (int v = 0; v < 5; v++) begin
      wait_fs();
      step();
      R = vecs[v].r; G = vecs[v].g; B = vecs[v].b; bright = vecs[v].br;
      wait_fs();
      on_cnt = 0; r0_or = '0; g4_or = '0;
      for (int k = 1; k < FRAME; k++) begin
        step();
        if (row_n == 5'b11110) begin
          if (col_r != 5'd0) on_cnt++;
          r0_or = r0_or | col_r;
        end
        if (row_n == 5'b01111) g4_or = g4_or | col_g;
      end
      chk($sformatf("vec%0d_on_cycles", v), 32'(on_cnt), 32'(vecs[v].exp_on));
      chk($sformatf("vec%0d_row0_r", v), 32'(r0_or), 32'(vecs[v].exp_r0));
      chk($sformatf("vec%0d_row4_g", v), 32'(g4_or), 32'(vecs[v].exp_g4));
    end

    // Mid-frame input change must not tear the current frame.
    wait_fs();
    step();
    R = '1; G = '1; B = '1; bright = 3'd7;
    wait_fs();
    repeat (74) step();
    R = '0; bright = 3'd0;
    repeat (133 - 74) step();
    chk("latch_row3_r", 32'(col_r), 32'h1f);
    chk("latch_row3_bright", 32'(col_g), 32'h1f);
    wait_fs();
    repeat (3) step();
    chk("next_frame_r", 32'(col_r), 32'h0);
    chk("next_frame_g_sub0", 32'(col_g), 32'h1f);
    repeat (4) step();
    chk("next_frame_bright", 32'(col_g), 32'h0);

    // Reset pulse in row 3 sub-step 5 discards the latched frame.
    R = '1; G = '1; B = '1; bright = 3'd7;
    wait_fs();
    step();
    R = 25'h0000001; G = '0; B = '0;
    repeat (124) step();
    chk("pre_reset_row3", 32'(row_n), 32'h17);
    rst = 1'b1;
    #1;
    chk("reset_mid_row_n", 32'(row_n), 32'h1f);
    chk("reset_mid_col_r", 32'(col_r), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("reset_mid_load", 32'(frame_start), 32'h1);
    repeat (3) step();
    chk("reset_mid_row0", 32'(row_n), 32'h1e);
    chk("reset_mid_new_frame", 32'(col_r), 32'h01);

    // Three more frames of free running under the per-cycle checks.
    repeat (3 * FRAME) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
